// File: rtl/ft_cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ft_cla_pkg
// Description : Shared constants and voter helper for the fault-tolerant CLA.
// Revision    : 1.0 - initial release
// ============================================================================
package ft_cla_pkg;

  localparam int GROUP_W = 4;

  localparam logic [1:0] INJ_NONE = 2'd0;
  localparam logic [1:0] INJ_C1   = 2'd1;
  localparam logic [1:0] INJ_C12  = 2'd2;
  localparam logic [1:0] INJ_CGL  = 2'd3;

  function automatic logic MAJ3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ft_cla_group.sv
`default_nettype none
// ============================================================================
// Module      : ft_cla_group
// Description : Combinational 4-bit group with triplicated, voted carries.
// Revision    : 1.0 - initial release
// ============================================================================
module ft_cla_group
  import ft_cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  input  logic [1:0]         inj_mode,
  input  logic [GROUP_W-1:0] inj_mask,
  output logic [GROUP_W-1:0] sum,
  output logic               cout,
  output logic               fault
);

  logic [GROUP_W-1:0] w_g;
  logic [GROUP_W-1:0] w_p;
  logic [GROUP_W-1:0] w_cgl;
  logic               w_inv1;
  logic               w_inv2;
  logic               w_invg;

  assign w_g    = a & b;
  assign w_p    = a ^ b;
  assign w_inv1 = (inj_mode == INJ_C1) || (inj_mode == INJ_C12);
  assign w_inv2 = (inj_mode == INJ_C12);
  assign w_invg = (inj_mode == INJ_CGL);

  // Lookahead copy: sum-of-products from group operands and group carry-in only
  always_comb begin
    logic v_acc;
    logic v_prop;
    w_cgl = '0;
    for (int i = 0; i < GROUP_W; i++) begin
      v_acc  = 1'b0;
      v_prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        v_acc  = v_acc | (w_g[j] & v_prop);
        v_prop = v_prop & w_p[j];
      end
      w_cgl[i] = v_acc | (v_prop & cin);
    end
  end

  always_comb begin
    logic v_c;
    logic v_raw;
    logic v_c1;
    logic v_c2;
    logic v_cx;
    v_c   = cin;
    sum   = '0;
    fault = 1'b0;
    for (int i = 0; i < GROUP_W; i++) begin
      v_raw  = w_g[i] | (w_p[i] & v_c);
      v_c1   = v_raw    ^ (w_inv1 & inj_mask[i]);
      v_c2   = v_raw    ^ (w_inv2 & inj_mask[i]);
      v_cx   = w_cgl[i] ^ (w_invg & inj_mask[i]);
      sum[i] = w_p[i] ^ v_c;
      fault  = fault | (v_c1 != v_c2) | (v_c2 != v_cx);
      v_c    = MAJ3(v_c1, v_c2, v_cx);
    end
    cout = v_c;
  end

endmodule
`default_nettype wire

// File: rtl/ft_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ft_cla_pipe
// Description : Pipelined fault-tolerant CLA, one 4-bit group per stage,
//               with handshake, fault flagging and saturating fault counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ft_cla_pipe
  import ft_cla_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       inj_mode,
  input  logic [WIDTH-1:0] inj_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_fault,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             err_sticky,
  input  logic             err_clr
);

  localparam int NG = WIDTH / GROUP_W;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic               w_stall;
  logic               w_fault_xfer;

  // Per-stage inputs (from ports for stage 0, from the previous register otherwise)
  logic [WIDTH-1:0]   w_a_src    [NG];
  logic [WIDTH-1:0]   w_b_src    [NG];
  logic [WIDTH-1:0]   w_m_src    [NG];
  logic [1:0]         w_mode_src [NG];
  logic               w_c_src    [NG];
  logic               w_f_src    [NG];
  logic               w_v_src    [NG];

  logic [GROUP_W-1:0] w_gsum     [NG];
  logic               w_gcout    [NG];
  logic               w_gfault   [NG];
  logic [WIDTH-1:0]   w_as_nxt   [NG];
  logic [WIDTH-1:0]   w_b_nxt    [NG];
  logic [WIDTH-1:0]   w_m_nxt    [NG];

  // r_as shifts right one group per stage: consumed operand A bits are
  // replaced from the top by sum bits, so the last stage holds the full sum.
  logic [WIDTH-1:0]   r_as   [NG];
  logic [WIDTH-1:0]   r_b    [NG];
  logic [WIDTH-1:0]   r_m    [NG];
  logic [1:0]         r_mode [NG];
  logic               r_c    [NG];
  logic               r_f    [NG];
  logic               r_v    [NG];
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sticky;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_a_src[k]    = in_a;
      assign w_b_src[k]    = in_b;
      assign w_m_src[k]    = inj_mask;
      assign w_mode_src[k] = inj_mode;
      assign w_c_src[k]    = in_cin;
      assign w_f_src[k]    = 1'b0;
      assign w_v_src[k]    = in_valid & in_ready;
    end else begin : g_body
      assign w_a_src[k]    = r_as[k-1];
      assign w_b_src[k]    = r_b[k-1];
      assign w_m_src[k]    = r_m[k-1];
      assign w_mode_src[k] = r_mode[k-1];
      assign w_c_src[k]    = r_c[k-1];
      assign w_f_src[k]    = r_f[k-1];
      assign w_v_src[k]    = r_v[k-1];
    end

    ft_cla_group u_group (
      .a        (w_a_src[k][GROUP_W-1:0]),
      .b        (w_b_src[k][GROUP_W-1:0]),
      .cin      (w_c_src[k]),
      .inj_mode (w_mode_src[k]),
      .inj_mask (w_m_src[k][GROUP_W-1:0]),
      .sum      (w_gsum[k]),
      .cout     (w_gcout[k]),
      .fault    (w_gfault[k])
    );

    if (WIDTH > GROUP_W) begin : g_shift
      assign w_as_nxt[k] = {w_gsum[k], w_a_src[k][WIDTH-1:GROUP_W]};
      assign w_b_nxt[k]  = {{GROUP_W{1'b0}}, w_b_src[k][WIDTH-1:GROUP_W]};
      assign w_m_nxt[k]  = {{GROUP_W{1'b0}}, w_m_src[k][WIDTH-1:GROUP_W]};
    end else begin : g_single
      assign w_as_nxt[k] = w_gsum[k];
      assign w_b_nxt[k]  = '0;
      assign w_m_nxt[k]  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NG; k++) begin
        r_as[k]   <= '0;
        r_b[k]    <= '0;
        r_m[k]    <= '0;
        r_mode[k] <= '0;
        r_c[k]    <= 1'b0;
        r_f[k]    <= 1'b0;
        r_v[k]    <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < NG; k++) begin
        r_as[k]   <= w_as_nxt[k];
        r_b[k]    <= w_b_nxt[k];
        r_m[k]    <= w_m_nxt[k];
        r_mode[k] <= w_mode_src[k];
        r_c[k]    <= w_gcout[k];
        r_f[k]    <= w_f_src[k] | w_gfault[k];
        r_v[k]    <= w_v_src[k];
      end
    end
  end

  assign w_fault_xfer = out_valid & out_ready & out_fault;

  // A clear coinciding with a faulty transfer still records that transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (err_clr) begin
      r_cnt    <= CNT_W'(w_fault_xfer);
      r_sticky <= w_fault_xfer;
    end else if (w_fault_xfer) begin
      if (r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_sticky <= 1'b1;
    end
  end

  assign out_valid  = r_v[NG-1];
  assign out_sum    = r_as[NG-1];
  assign out_cout   = r_c[NG-1];
  assign out_fault  = r_f[NG-1];
  assign fault_cnt  = r_cnt;
  assign err_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_ft_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ft_cla_pipe
// Description : Self-checking bench for ft_cla_pipe against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ft_cla_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [1:0]       inj_mode;
  logic [WIDTH-1:0] inj_mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_fault;
  logic [CNT_W-1:0] fault_cnt;
  logic             err_sticky;
  logic             err_clr;

  int errors = 0;
  int checks = 0;

  logic [WIDTH+1:0] exp_q[$];
  int               m_cnt = 0;
  logic             m_sticky = 1'b0;
  logic [WIDTH+1:0] cmp_e;
  logic             cmp_xfer;
  logic             acc;

  ft_cla_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .inj_mode(inj_mode), .inj_mask(inj_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_fault(out_fault),
    .fault_cnt(fault_cnt), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result {fault, cout, sum} from the bit-level carry rules; the lookahead
  // copy is taken arithmetically from the group operands and group carry-in.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic [1:0] md,
                                             input logic [WIDTH-1:0] mk);
    logic             c, gc, flt, c1, c2, cg;
    logic [WIDTH-1:0] s;
    logic [31:0]      t;
    int               base, pos, ga, gb, msk;
    c = cin; gc = cin; flt = 1'b0; s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pos  = i % 4;
      base = i - pos;
      if (pos == 0) gc = c;
      msk  = (1 << (pos + 1)) - 1;
      ga   = int'(a >> base) & msk;
      gb   = int'(b >> base) & msk;
      t    = 32'(ga + gb + int'(gc));
      cg   = t[pos+1];
      s[i] = a[i] ^ b[i] ^ c;
      c1   = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      c2   = c1;
      if (mk[i]) begin
        if (md == 2'd1) c1 = ~c1;
        if (md == 2'd2) begin c1 = ~c1; c2 = ~c2; end
        if (md == 2'd3) cg = ~cg;
      end
      if (!(c1 == c2 && c2 == cg)) flt = 1'b1;
      c = (c1 & c2) | (c1 & cg) | (c2 & cg);
    end
    return {flt, c, s};
  endfunction

  // Compare process: checks in the middle of each cycle, then applies the
  // events of the coming edge to the model.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    chk("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'(0));
      end else begin
        cmp_e = exp_q.pop_front();
        chk("result", 32'({out_fault, out_cout, out_sum}), 32'(cmp_e));
      end
    end
    if (rst) begin
      exp_q.delete();
      m_cnt    = 0;
      m_sticky = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, inj_mode, inj_mask));
      cmp_xfer = out_valid && out_ready && out_fault;
      if (err_clr) begin
        m_cnt    = cmp_xfer ? 1 : 0;
        m_sticky = cmp_xfer;
      end else if (cmp_xfer) begin
        if (m_cnt < CMAX) m_cnt++;
        m_sticky = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic ci, input logic [1:0] md, input logic [WIDTH-1:0] mk,
                            input logic [WIDTH-1:0] es, input logic ec, input logic ef);
    in_a = a; in_b = b; in_cin = ci; inj_mode = md; inj_mask = mk; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; inj_mode = 2'd0; inj_mask = '0;
    chk({nm, "_early"}, 32'(out_valid), 32'(0));
    tick();
    chk({nm, "_valid"}, 32'(out_valid), 32'(1));
    chk({nm, "_sum"}, 32'(out_sum), 32'(es));
    chk({nm, "_cout"}, 32'(out_cout), 32'(ec));
    chk({nm, "_fault"}, 32'(out_fault), 32'(ef));
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    inj_mode = 2'd0; inj_mask = '0; out_ready = 1'b1; err_clr = 1'b0;

    chk("model_ff01", 32'(model(8'hFF, 8'h01, 1'b0, 2'd0, 8'h00)), 32'(10'h100));
    chk("model_inj1", 32'(model(8'h03, 8'h01, 1'b0, 2'd1, 8'h01)), 32'(10'h204));
    chk("model_inj2", 32'(model(8'h03, 8'h01, 1'b0, 2'd2, 8'h01)), 32'(10'h202));
    chk("model_inj3", 32'(model(8'h03, 8'h01, 1'b0, 2'd3, 8'h01)), 32'(10'h204));
    chk("model_a55a", 32'(model(8'hA5, 8'h5A, 1'b1, 2'd0, 8'h00)), 32'(10'h100));

    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(out_sum), 32'(0));
    chk("rst_cout", 32'(out_cout), 32'(0));
    chk("rst_fault", 32'(out_fault), 32'(0));
    chk("rst_cnt", 32'(fault_cnt), 32'(0));
    chk("rst_sticky", 32'(err_sticky), 32'(0));
    rst = 1'b0;
    tick();

    send_check("ff_plus_01", 8'hFF, 8'h01, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("ff01_cnt", 32'(fault_cnt), 32'(0));

    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A; in_cin = 1'b1;
    tick();
    in_a = 8'h0F; in_b = 8'h01; in_cin = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("b2b_first_sum", 32'({out_valid, out_cout, out_sum}), 32'(10'h300));
    tick();
    chk("b2b_second_sum", 32'({out_valid, out_cout, out_sum}), 32'(10'h210));
    tick();

    err_clr = 1'b1; tick(); err_clr = 1'b0;
    send_check("inj_c1", 8'h03, 8'h01, 1'b0, 2'd1, 8'h01, 8'h04, 1'b0, 1'b1);
    chk("inj_c1_cnt", 32'(fault_cnt), 32'(1));
    chk("inj_c1_sticky", 32'(err_sticky), 32'(1));
    send_check("inj_c12", 8'h03, 8'h01, 1'b0, 2'd2, 8'h01, 8'h02, 1'b0, 1'b1);
    send_check("inj_cgl", 8'h03, 8'h01, 1'b0, 2'd3, 8'h01, 8'h04, 1'b0, 1'b1);

    // Stall: hold the consumer off while three operands are offered
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      in_a = (n == 0) ? 8'h11 : (n == 1) ? 8'h80 : 8'hFE;
      in_b = (n == 0) ? 8'h22 : (n == 1) ? 8'h7F : 8'h01;
      in_cin = (n == 2);
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
        if (n == 2 && w == 3) begin
          chk("stall_in_ready", 32'(in_ready), 32'(0));
          chk("stall_hold_sum", 32'({out_valid, out_sum}), 32'(9'h133));
          out_ready = 1'b1;
          #1;
        end
        acc = in_ready;
        tick();
      end
      chk("stall_accept", 32'(acc), 32'(1));
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("stall_drained", 32'(exp_q.size()), 32'(0));

    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_cin    = 1'($urandom);
      inj_mode  = ($urandom_range(0, 7) < 4) ? 2'd0 : 2'($urandom_range(1, 3));
      inj_mask  = WIDTH'($urandom);
      err_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1; inj_mode = 2'd0; inj_mask = '0;
    repeat (6) tick();
    chk("random_drained", 32'(exp_q.size()), 32'(0));

    err_clr = 1'b1; tick(); err_clr = 1'b0;
    in_valid = 1'b1; in_a = 8'h03; in_b = 8'h01; in_cin = 1'b0; inj_mode = 2'd1; inj_mask = 8'h01;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("sat_cnt", 32'(fault_cnt), 32'(3));
    chk("sat_sticky", 32'(err_sticky), 32'(1));

    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; inj_mode = 2'd0; inj_mask = '0;
    tick();
    chk("clr_xfer_valid", 32'({out_valid, out_fault}), 32'(2'b11));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_xfer_cnt", 32'(fault_cnt), 32'(1));
    chk("clr_xfer_sticky", 32'(err_sticky), 32'(1));

    in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'(0));
    chk("midrst_cnt", 32'(fault_cnt), 32'(0));
    chk("midrst_sticky", 32'(err_sticky), 32'(0));
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("midrst_idle", 32'(out_valid), 32'(0));
    repeat (4) tick();
    chk("final_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
